// File: rtl/rr_arbiter_8.sv
// Eight-requester round-robin arbiter with sticky, registered one-hot grants.
// Optional grant hold timeout is enabled with `define RR_ARB_HOLD_TIMEOUT_EN.
module rr_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam int unsigned N_REQ = 8;
  localparam int unsigned ID_W  = 3;
  localparam int unsigned CNT_W = 8;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state, state_nxt;
  logic [N_REQ-1:0]  gnt_nxt;
  logic [ID_W-1:0]   gnt_id_nxt;
  logic              gnt_valid_nxt;
  logic              timeout_nxt;
  logic [ID_W-1:0]   last_id, last_id_nxt;
  logic [N_REQ-1:0]  arb_req;
  logic [ID_W-1:0]   arb_last;
  logic [ID_W:0]     arb_res;
  logic              owner_rel;
  logic              hold_hit;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
  logic [CNT_W-1:0]  hold_cnt, hold_cnt_nxt;
`endif

  // Highest set index below l wins; otherwise highest set index overall. MSB of result = found.
  function automatic logic [ID_W:0] arb(input logic [N_REQ-1:0] r, input logic [ID_W-1:0] l);
    logic [N_REQ-1:0] m;
    logic [ID_W:0]    res;
    res = '0;
    for (int i = 0; i < int'(N_REQ); i++) m[i] = r[i] && (ID_W'(i) < l);
    if (m == '0) m = r;
    for (int i = 0; i < int'(N_REQ); i++) if (m[i]) res = {1'b1, ID_W'(i)};
    return res;
  endfunction

  // On release or timeout the current owner is excluded and becomes the rotation point.
  assign arb_req  = (state == GRANT) ? (req & ~gnt) : req;
  assign arb_last = (state == GRANT) ? gnt_id : last_id;
  assign arb_res  = arb(arb_req, arb_last);
  assign owner_rel = !req[gnt_id];
`ifdef RR_ARB_HOLD_TIMEOUT_EN
  assign hold_hit = (hold_cnt == CNT_W'(MAX_HOLD - 1));
`else
  assign hold_hit = 1'b0;
`endif

  always_comb begin
    state_nxt     = state;
    gnt_nxt       = gnt;
    gnt_id_nxt    = gnt_id;
    gnt_valid_nxt = gnt_valid;
    timeout_nxt   = 1'b0;
    last_id_nxt   = last_id;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
    hold_cnt_nxt  = hold_cnt;
`endif
    case (state)
      IDLE: begin
        if (arb_res[ID_W]) begin
          state_nxt     = GRANT;
          gnt_nxt       = N_REQ'(1) << arb_res[ID_W-1:0];
          gnt_id_nxt    = arb_res[ID_W-1:0];
          gnt_valid_nxt = 1'b1;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
          hold_cnt_nxt  = '0;
`endif
        end
      end
      GRANT: begin
        if (owner_rel || hold_hit) begin
          last_id_nxt = gnt_id;
          timeout_nxt = !owner_rel;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
          hold_cnt_nxt = '0;
`endif
          if (arb_res[ID_W]) begin
            gnt_nxt       = N_REQ'(1) << arb_res[ID_W-1:0];
            gnt_id_nxt    = arb_res[ID_W-1:0];
            gnt_valid_nxt = 1'b1;
          end else begin
            state_nxt     = IDLE;
            gnt_nxt       = '0;
            gnt_id_nxt    = '0;
            gnt_valid_nxt = 1'b0;
          end
        end else begin
`ifdef RR_ARB_HOLD_TIMEOUT_EN
          if (hold_cnt != {CNT_W{1'b1}}) hold_cnt_nxt = hold_cnt + CNT_W'(1);
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      last_id   <= '0;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
      hold_cnt  <= '0;
`endif
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      gnt_id    <= gnt_id_nxt;
      gnt_valid <= gnt_valid_nxt;
      timeout   <= timeout_nxt;
      last_id   <= last_id_nxt;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
      hold_cnt  <= hold_cnt_nxt;
`endif
    end
  end

endmodule
